reqack_src_ctrl: RTL and testbench

//  Source-side (clka) initiator for the toggle req/ack CDC handshake. Buffers local words in a small FIFO
//  and drives the handshake one word at a time: loads data_a, pulses req for one cycle, holds data_a

---
 rtl/reqack_pkg.sv | 18 +
 rtl/reqack_fifo.sv | 55 +++++
 rtl/reqack_src_ctrl.sv | 142 ++++++++++++++
 tb/tb_reqack_src_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reqack_pkg.sv
// Shared types and helpers for the req/ack source-side controller.
package reqack_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/reqack_fifo.sv
// Single-clock FIFO buffering local words ahead of the req/ack handshake.
module reqack_fifo
    import reqack_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
)(
    input  logic                        clka,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr];

    // Storage needs no reset; emptiness is tracked by pointers and level.
    always_ff @(posedge clka) begin
        if (push && !full)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push && !full, pop && !empty})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/reqack_src_ctrl.sv
// Source-side (clka) initiator of the toggle req/ack CDC handshake, fed from a small FIFO.
// Optional watchdog on the acknowledge wait is enabled by defining REQACK_TIMEOUT_EN.
module reqack_src_ctrl
    import reqack_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
)(
    input  logic                             clka,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             in_ready,
    output logic                             req,
    output logic [DATA_WIDTH-1:0]            data_a,
    input  logic                             ack_s,
    output logic                             busy,
    output logic                             done,
    output logic [level_w(FIFO_DEPTH)-1:0]   level,
    output logic                             timeout_err,
    input  logic                             err_clr
);

    state_t                state, state_nxt;
    logic                  req_nxt, done_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [DATA_WIDTH-1:0] head;
    logic                  push, pop, full, empty;
    logic                  tmo_load, err_set;

    assign in_ready = !full;
    assign push     = in_valid && !full;

    reqack_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clka  (clka),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

`ifdef REQACK_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_last;

    // The terminal cycle is the last of TIMEOUT_CYCLES cycles spent in WAIT.
    assign tmo_last = (tmo_cnt == 16'd1);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (tmo_load)
            tmo_cnt <= 16'(TIMEOUT_CYCLES);
        else if (state == WAIT && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - 16'd1;
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n)
            timeout_err <= 1'b0;
        else if (err_set)
            timeout_err <= 1'b1;
        else if (state == ERR && err_clr)
            timeout_err <= 1'b0;
    end
`else
    logic unused_tmo;
    assign unused_tmo  = err_clr ^ tmo_load ^ err_set ^ (TIMEOUT_CYCLES == 0);
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        req_nxt   = 1'b0;
        done_nxt  = 1'b0;
        data_nxt  = data_a;
        pop       = 1'b0;
        tmo_load  = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    data_nxt  = head;
                    req_nxt   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                tmo_load  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // An acknowledge in the terminal cycle takes priority over the timeout.
                if (ack_s) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef REQACK_TIMEOUT_EN
                else if (tmo_last) begin
                    err_set   = 1'b1;
                    state_nxt = ERR;
                end
`endif
            end
            ERR: begin
`ifdef REQACK_TIMEOUT_EN
                if (err_clr)
                    state_nxt = IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            req    <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            data_a <= '0;
        end else begin
            state  <= state_nxt;
            req    <= req_nxt;
            done   <= done_nxt;
            busy   <= (state_nxt != IDLE);
            data_a <= data_nxt;
        end
    end

endmodule

// File: tb/tb_reqack_src_ctrl.sv
// Directed bench for reqack_src_ctrl: expected words queued at issue, checked by a req monitor.
module tb_reqack_src_ctrl;

    localparam int DW = 8;
    localparam int FD = 4;
    localparam int TC = 16;

    logic          clka = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          req;
    logic [DW-1:0] data_a;
    logic          ack_s;
    logic          busy;
    logic          done;
    logic [2:0]    level;
    logic          timeout_err;
    logic          err_clr;

    int vectors    = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] held;

    always #5 clka = ~clka;

    reqack_src_ctrl #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (FD),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clka        (clka),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .req         (req),
        .data_a      (data_a),
        .ack_s       (ack_s),
        .busy        (busy),
        .done        (done),
        .level       (level),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clka);
    endtask

    // Monitor: every req pulse must carry the next queued word; data_a holds until the transfer ends.
    always @(negedge clka) begin
        if (rst_n && req) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_req: got data 0x%0h expected no request", data_a);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (data_a !== e) begin
                    miscompares++;
                    $display("FAIL req_data: got 0x%0h expected 0x%0h", data_a, e);
                end
            end
            held = data_a;
        end else if (rst_n && busy) begin
            vectors++;
            if (data_a !== held) begin
                miscompares++;
                $display("FAIL data_hold: got 0x%0h expected 0x%0h", data_a, held);
            end
        end
    end

    task automatic send_word(input logic [DW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    // Waits for WAIT (busy, no req), acknowledges, and checks the done pulse plus the idle gap.
    task automatic ack_word();
        int n = 0;
        while (!(busy && !req) && n < 50) begin
            tick();
            n++;
        end
        check("wait_state", {31'd0, busy && !req}, 32'd1);
        ack_s = 1'b1;
        tick();
        ack_s = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_drop", {31'd0, busy}, 32'd0);
        check("gap_req", {31'd0, req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        ack_s    = 1'b0;
        err_clr  = 1'b0;
        held     = '0;

        // 1: reset holds everything at rest even with in_valid asserted
        repeat (3) tick();
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_data_a", {24'd0, data_a}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("post_rst_level", {29'd0, level}, 32'd0);

        // 2: single word, latency and hold
        send_word(8'h3C);
        check("lat_level1", {29'd0, level}, 32'd1);
        check("lat_no_req_yet", {31'd0, req}, 32'd0);
        tick();
        check("lat_req", {31'd0, req}, 32'd1);
        check("lat_busy", {31'd0, busy}, 32'd1);
        check("lat_level0", {29'd0, level}, 32'd0);
        repeat (5) tick();
        check("hold_req_low", {31'd0, req}, 32'd0);
        check("hold_data", {24'd0, data_a}, 32'h3C);
        ack_word();
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // 3: burst fills the FIFO, then drain in order
        for (int i = 1; i <= 5; i++) send_word(8'(i));
        check("burst_level_full", {29'd0, level}, 32'd4);
        check("burst_in_ready", {31'd0, in_ready}, 32'd0);
        ack_word();
        send_word(8'h06);
        for (int i = 2; i <= 6; i++) begin
            ack_word();
            if (i != 6) begin
                tick();
                check("b2b_req", {31'd0, req}, 32'd1);
            end
        end
        tick();
        check("burst_empty", {29'd0, level}, 32'd0);

        // 4: stray acks in IDLE and in the REQ cycle are ignored
        ack_s = 1'b1;
        tick();
        ack_s = 1'b0;
        check("stray_idle_done", {31'd0, done}, 32'd0);
        check("stray_idle_busy", {31'd0, busy}, 32'd0);
        send_word(8'h77);
        tick();
        check("stray_req_cycle", {31'd0, req}, 32'd1);
        ack_s = 1'b1;
        tick();
        ack_s = 1'b0;
        check("stray_req_done", {31'd0, done}, 32'd0);
        check("stray_req_busy", {31'd0, busy}, 32'd1);
        repeat (2) tick();
        check("stray_still_busy", {31'd0, busy}, 32'd1);
        ack_word();

`ifdef REQACK_TIMEOUT_EN
        // 5: timeout, error recovery, and ack in the terminal cycle
        begin
            int n = 0;
            send_word(8'h66);
            while (!(busy && !req) && n < 50) begin tick(); n++; end
            n = 0;
            while (!timeout_err && n < 40) begin tick(); n++; end
            check("tmo_cycles", 32'(n), 32'(TC));
            check("tmo_err", {31'd0, timeout_err}, 32'd1);
            send_word(8'h67);
            for (int i = 0; i < 4; i++) check("err_no_req", {31'd0, req}, 32'd0);
            repeat (3) begin
                tick();
                check("err_no_req", {31'd0, req}, 32'd0);
            end
            check("err_busy", {31'd0, busy}, 32'd1);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check("err_clr", {31'd0, timeout_err}, 32'd0);
            ack_word();
            send_word(8'h68);
            n = 0;
            while (!(busy && !req) && n < 50) begin tick(); n++; end
            repeat (TC - 1) tick();
            ack_s = 1'b1;
            tick();
            ack_s = 1'b0;
            check("term_ack_done", {31'd0, done}, 32'd1);
            check("term_ack_no_err", {31'd0, timeout_err}, 32'd0);
        end
`endif

        // 6: reset during WAIT with words buffered
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
        repeat (2) tick();
        check("mid_level3", {29'd0, level}, 32'd3);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_level", {29'd0, level}, 32'd0);
        check("mid_rst_req", {31'd0, req}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_data", {24'd0, data_a}, 32'd0);
        tick();
        rst_n = 1'b1;
        held  = '0;
        tick();
        send_word(8'h55);
        tick();
        check("post_rst_req", {31'd0, req}, 32'd1);
        ack_word();
        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
